apb_slave_regs: RTL
===================

# apb_slave_regs

APB completer holding a small word-addressed register file; it is the responder end of the bus driven by `master_apb`. It decodes `PSEL`/`PENABLE`/`PWRITE`/`PADDR`, commits writes, returns read data on `PRDATA`, and drives `PREADY`/`PSLVERR`. Optional wait-state insertion lets benches exercise the master's `PREADY`-low path.

## Interface
- `ADDR_WIDTH`, 8: width of `PADDR`; `PADDR` is a word index, not a byte address.
- `DATA_WIDTH`, 32: width of `PWDATA`/`PRDATA`.
- `MEM_DEPTH`, 16: number of registers; valid indices are 0..MEM_DEPTH-1.
- `WAIT_CYCLES`, 2: wait states per transfer; used only when `APB_SLAVE_WAIT_EN` is defined. Legal range 0..15.
- `PCLK` input 1: clock; all logic on the rising edge.
- `PRESET` input 1: reset, synchronous and active-high.
- `PSEL` input 1: completer select.
- `PENABLE` input 1: access phase indicator.
- `PWRITE` input 1: 1 = write, 0 = read.
- `PADDR` input ADDR_WIDTH: register index.
- `PWDATA` input DATA_WIDTH: write data.
- `PREADY` output 1: transfer completes in a cycle where `PSEL & PENABLE & PREADY`.
- `PRDATA` output DATA_WIDTH: read data; valid while `PREADY`=1 on a read.
- `PSLVERR` output 1: error flag; valid while `PREADY`=1.

## Operation
- **Reset** (`PRESET`=1 at an edge): state=IDLE, `PREADY`=0, `PSLVERR`=0, `PRDATA`=0, wait counter=0, all MEM_DEPTH registers=0.
  - Reset overrides everything, including mid-transfer; an in-flight write is discarded.
- **IDLE**, `PREADY`=0. At an edge with `PSEL`=1 & `PENABLE`=0 (setup cycle):
  - latch `PADDR`, `PWRITE`, `PWDATA`;
  - set `err` = (`PADDR` >= MEM_DEPTH);
  - load counter = WAIT_CYCLES;
  - go to WAIT if the counter value is >0, otherwise go to DONE.
  - `PSEL`=1 & `PENABLE`=1 seen in IDLE is a protocol error: ignored, stay IDLE.
- **WAIT**, `PREADY`=0.
  - At each edge with `PSEL`=1, decrement the counter; when it reaches 0, go to DONE.
  - `PSEL`=0 at any edge aborts: go to IDLE, no write.
- **Entering DONE** (registered outputs):
  - `PREADY`=1;
  - `PSLVERR`=`err`;
  - `PRDATA` = mem[latched addr] for a read with no error, otherwise 0. Writes also drive `PRDATA`=0.
- **DONE**, `PREADY`=1.
  - At an edge with `PSEL`=1 & `PENABLE`=1: completion.
    - If latched write and `err`=0, mem[addr] <= latched data.
    - Go to IDLE, `PREADY`=0, `PSLVERR`=0.
  - `PSEL`=0: abort to IDLE, no write.
- Out-of-range access: `PSLVERR`=1, memory unchanged. Reads return 0.
- Signals are sampled in the setup cycle only. `PADDR`/`PWDATA` changes during the access phase have no effect.

## Timing
- Zero-wait transfer (WAIT_CYCLES=0 or macro off):
  - setup cycle T0;
  - access cycle T1 with `PREADY`=1;
  - completion at the T1→T2 edge.
  - Total 2 bus cycles.
- With N wait states: `PREADY`=0 for the first N access cycles and 1 in access cycle N+1. Total N+2 cycles.
- Write data is visible to a read whose setup cycle follows the completion edge. Back-to-back transfers need no idle cycle.
- Counter width is $clog2(WAIT_CYCLES+1), minimum 1 bit.
- `PRDATA`/`PSLVERR` hold their values for the whole `PREADY`=1 cycle and clear at the completion edge.

## Configuration
- `APB_SLAVE_WAIT_EN` defined: the counter uses WAIT_CYCLES, and the WAIT state and counter logic are compiled in.
- Not defined: the counter logic is removed; IDLE goes directly to DONE; every transfer is zero-wait regardless of WAIT_CYCLES.

## Test plan
- **Reset:** hold `PRESET`=1 for 3 cycles, then release → `PREADY`=0, `PSLVERR`=0, `PRDATA`=0; a read of index 5 returns 0.
- **Write then read, macro off:** write 9 to index 3, then read index 3.
  - Each transfer has `PREADY`=1 in its first access cycle.
  - The read gives `PRDATA`=9, `PSLVERR`=0.
- **Wait states, macro on, WAIT_CYCLES=2:** write 13 to index 7.
  - `PREADY` is 0 for 2 access cycles, then 1.
  - A read of index 7 gives `PRDATA`=13 after the same 2-cycle stall.
- **Out of range, MEM_DEPTH=16:** write 0xDEAD to index 20 → `PSLVERR`=1 with `PREADY`=1.
  - A read of index 20 gives `PRDATA`=0, `PSLVERR`=1.
  - Index 4 (20 mod 16) is unchanged at 0.
- **Abort, macro on:** write 0x55 to index 2, dropping `PSEL` in the first wait cycle → returns to IDLE with `PREADY`=0; a read of index 2 returns 0.
- **Reset mid-transfer:** assert `PRESET` during the access phase of a write of 0x77 to index 1 → outputs go to 0 on the next edge; a read of index 1 returns 0.

Source files
------------

// File: rtl/apb_slave_regs.sv
// -----------------------------------------------------------------------------
// apb_slave_regs
//   APB completer backed by a small word-addressed register file.
//   PADDR is a word index (not a byte address). Out-of-range indices
//   (PADDR >= MEM_DEPTH) complete with PSLVERR=1, read 0 and never write.
//
//   Optional feature macro: APB_SLAVE_WAIT_EN
//     defined   : each transfer inserts WAIT_CYCLES wait states (0..15)
//     undefined : wait-state counter is compiled out; every transfer is
//                 zero-wait regardless of WAIT_CYCLES
//
// Ports
//   PCLK     in   clock, rising edge
//   PRESET   in   synchronous active-high reset
//   PSEL     in   completer select
//   PENABLE  in   access phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   [ADDR_WIDTH-1:0] register index
//   PWDATA   in   [DATA_WIDTH-1:0] write data
//   PREADY   out  transfer completes on PSEL & PENABLE & PREADY
//   PRDATA   out  [DATA_WIDTH-1:0] read data, valid while PREADY=1
//   PSLVERR  out  error flag, valid while PREADY=1
// -----------------------------------------------------------------------------
module apb_slave_regs #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  // Transfer attributes captured in the setup cycle
  logic [IDX_W-1:0]        r_idx;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_err;

  logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

  logic                    r_pready;
  logic [DATA_WIDTH-1:0]   r_prdata;
  logic                    r_pslverr;

  logic                    w_setup;
  logic                    w_access;
  logic                    w_paddr_oor;
  logic                    w_capture;
  logic                    w_enter_done;
  logic                    w_complete;
  logic                    w_mem_we;
  logic [IDX_W-1:0]        w_src_idx;
  logic                    w_src_write;
  logic                    w_src_err;
  logic                    w_pready_nxt;
  logic [DATA_WIDTH-1:0]   w_prdata_nxt;
  logic                    w_pslverr_nxt;

  assign w_setup     = PSEL & ~PENABLE;
  assign w_access    = PSEL & PENABLE;
  assign w_paddr_oor = ({1'b0, PADDR} >= DEPTH_EXT);
  assign w_capture   = (r_state == S_IDLE) && w_setup;

`ifdef APB_SLAVE_WAIT_EN
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_cnt <= '0;
    end else if (w_capture) begin
      r_cnt <= CNT_W'(WAIT_CYCLES);
    end else if (r_state == S_WAIT) begin
      if (PSEL) r_cnt <= r_cnt - 1'b1;
      else      r_cnt <= '0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        // PSEL & PENABLE without a setup cycle is ignored
        if (w_setup) begin
`ifdef APB_SLAVE_WAIT_EN
          w_state_nxt = (WAIT_CYCLES != 0) ? S_WAIT : S_DONE;
`else
          w_state_nxt = S_DONE;
`endif
        end
      end
`ifdef APB_SLAVE_WAIT_EN
      S_WAIT: begin
        if (!PSEL)
          w_state_nxt = S_IDLE;
        else if (r_cnt == CNT_W'(1))
          w_state_nxt = S_DONE;   // this edge's decrement reaches zero
      end
`endif
      S_DONE: begin
        if (!PSEL || PENABLE) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (next values of the registered bus outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_enter_done = (r_state != S_DONE) && (w_state_nxt == S_DONE);
    w_complete   = (r_state == S_DONE) && w_access;
    w_mem_we     = w_complete && r_write && !r_err;

    // Zero-wait entry happens on the setup edge itself, before the latches
    // hold the transfer, so the live bus is used as the source there.
    if (r_state == S_IDLE) begin
      w_src_idx   = PADDR[IDX_W-1:0];
      w_src_write = PWRITE;
      w_src_err   = w_paddr_oor;
    end else begin
      w_src_idx   = r_idx;
      w_src_write = r_write;
      w_src_err   = r_err;
    end

    w_pready_nxt  = 1'b0;
    w_prdata_nxt  = '0;
    w_pslverr_nxt = 1'b0;
    if (w_enter_done) begin
      w_pready_nxt  = 1'b1;
      w_pslverr_nxt = w_src_err;
      if (!w_src_write && !w_src_err) w_prdata_nxt = r_mem[w_src_idx];
    end else if (w_state_nxt == S_DONE) begin
      w_pready_nxt  = r_pready;
      w_prdata_nxt  = r_prdata;
      w_pslverr_nxt = r_pslverr;
    end
  end

  // ---------------------------------------------------------------------------
  // Setup-cycle latches and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_idx     <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      if (w_capture) begin
        r_idx   <= PADDR[IDX_W-1:0];
        r_write <= PWRITE;
        r_wdata <= PWDATA;
        r_err   <= w_paddr_oor;
      end
      r_pready  <= w_pready_nxt;
      r_prdata  <= w_prdata_nxt;
      r_pslverr <= w_pslverr_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_mem_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign PREADY  = r_pready;
  assign PRDATA  = r_prdata;
  assign PSLVERR = r_pslverr;

endmodule
